// File: rtl/ryuki_datatypes.sv
// ---------------------------------------------------------------------------
// ryuki_datatypes : shared trace record types and trace FIFO entry layout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ryuki_datatypes;

  localparam int c_src_idx_w = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_output;

  typedef struct packed {
    trace_output            rec;
    logic [c_src_idx_w-1:0] src;
  } trace_fifo_entry;

endpackage

`default_nettype wire

// File: rtl/trace_arbiter_if.sv
// ---------------------------------------------------------------------------
// trace_arbiter_if : tracker-side capture bus and consumer-side output bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trace_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  import ryuki_datatypes::*;

  logic [NUM_SRC-1:0]              src_ready;
  trace_output [NUM_SRC-1:0]       src_data;
  logic [31:0]                     counter;
  logic                            out_valid;
  trace_output                     out_data;
  logic [SRC_W-1:0]                out_src;
  logic                            out_ready;
  logic [31:0]                     drop_count;
  logic [31:0]                     last_drop_time;

  modport master (
    output src_ready, src_data, counter, out_ready,
    input  out_valid, out_data, out_src, drop_count, last_drop_time
  );

  modport slave (
    input  src_ready, src_data, counter, out_ready,
    output out_valid, out_data, out_src, drop_count, last_drop_time
  );

endinterface

`default_nettype wire

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo : power-of-two FIFO with show-ahead head and wrap-bit pointers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      i_push,
  input  trace_fifo_entry i_wr_data,
  input  wire logic      i_pop,
  output trace_fifo_entry o_rd_data,
  output logic           o_full,
  output logic           o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  trace_fifo_entry r_mem [DEPTH];
  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[c_aw] != r_rptr[c_aw]) && (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign w_rd_en   = i_pop & ~o_empty;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign w_wr_en   = i_push & (~o_full | w_rd_en);
  assign o_rd_data = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr[c_aw-1:0]] <= i_wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/trace_arbiter.sv
// ---------------------------------------------------------------------------
// trace_arbiter : edge-captures per-source trace records, round-robin merges
//                 them into one FIFO stream and accounts for lost records
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trace_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input wire logic        clk,
  input wire logic        rst,
  trace_arbiter_if.slave  bus
);
  import ryuki_datatypes::*;

  localparam int c_src_w = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        r_prev_ready;
  logic [NUM_SRC-1:0]        r_hold_valid;
  trace_output [NUM_SRC-1:0] r_hold_data;
  logic                      r_armed;
  logic [c_src_w-1:0]        r_rr_ptr;
  logic [31:0]               r_drop_count;
  logic [31:0]               r_last_drop_time;

  logic [NUM_SRC-1:0]        w_edge;
  logic [NUM_SRC-1:0]        w_free;
  logic [NUM_SRC-1:0]        w_capture;
  logic [NUM_SRC-1:0]        w_drop;
  logic [NUM_SRC-1:0]        w_grant_vec;
  logic                      w_grant;
  logic [c_src_w-1:0]        w_grant_idx;
  logic [c_src_w:0]          w_sum;
  logic [c_src_w-1:0]        w_idx;
  logic [c_src_w:0]          w_next_ptr;
  logic [31:0]               w_num_drops;
  logic [32:0]               w_drop_sum;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  trace_fifo_entry           w_wr_entry;
  trace_fifo_entry           w_rd_entry;

  // r_armed masks the first cycle after reset so a level already high is not an edge.
  assign w_edge    = r_armed ? (bus.src_ready & ~r_prev_ready) : '0;
  assign w_pop     = ~w_empty & bus.out_ready;
  assign w_free    = ~r_hold_valid | w_grant_vec;
  assign w_capture = w_edge & w_free;
  assign w_drop    = w_edge & ~w_free;

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_src_w+1)'(k);
      if (w_sum >= (c_src_w+1)'(NUM_SRC)) w_sum = w_sum - (c_src_w+1)'(NUM_SRC);
      w_idx = w_sum[c_src_w-1:0];
      if (!w_grant && r_hold_valid[w_idx] && (!w_full || w_pop)) begin
        w_grant     = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_vec = '0;
    if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
    w_next_ptr = {1'b0, w_grant_idx} + 1'b1;
    if (w_next_ptr >= (c_src_w+1)'(NUM_SRC)) w_next_ptr = '0;
    w_num_drops = '0;
    for (int i = 0; i < NUM_SRC; i++) w_num_drops = w_num_drops + 32'(w_drop[i]);
    w_drop_sum = {1'b0, r_drop_count} + {1'b0, w_num_drops};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed          <= 1'b0;
      r_prev_ready     <= '0;
      r_hold_valid     <= '0;
      r_rr_ptr         <= '0;
      r_drop_count     <= '0;
      r_last_drop_time <= '0;
    end else begin
      r_armed      <= 1'b1;
      r_prev_ready <= bus.src_ready;
      r_hold_valid <= (r_hold_valid & ~w_grant_vec) | w_capture;
      if (w_grant) r_rr_ptr <= w_next_ptr[c_src_w-1:0];
      if (|w_drop) begin
        r_drop_count     <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        r_last_drop_time <= bus.counter;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_hold
      always_ff @(posedge clk) begin
        if (w_capture[g]) r_hold_data[g] <= bus.src_data[g];
      end
    end
  endgenerate

  assign w_wr_entry.rec = r_hold_data[w_grant_idx];
  assign w_wr_entry.src = c_src_idx_w'(w_grant_idx);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_grant),
    .i_wr_data (w_wr_entry),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_entry),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign bus.out_valid      = ~w_empty;
  assign bus.out_data       = w_rd_entry.rec;
  assign bus.out_src        = w_empty ? '0 : w_rd_entry.src[c_src_w-1:0];
  assign bus.drop_count     = r_drop_count;
  assign bus.last_drop_time = r_last_drop_time;

endmodule

`default_nettype wire

// File: tb/tb_trace_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trace_arbiter : directed stimulus with queued expectations for trace_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trace_arbiter;
  import ryuki_datatypes::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  trace_arbiter_if #(.NUM_SRC(2)) bus ();

  trace_arbiter #(
    .NUM_SRC    (2),
    .FIFO_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_output rec(input logic [31:0] a);
    trace_output r;
    r.addr = a;
    r.data = a ^ 32'h5A5A_0000;
    return r;
  endfunction

  task automatic expect_rec(input logic [31:0] a, input logic s);
    exp_t e;
    e.addr = a;
    e.data = a ^ 32'h5A5A_0000;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic s, input logic [31:0] a, input logic exp_it);
    bus.src_data[s]  = rec(a);
    bus.src_ready[s] = 1'b1;
    if (exp_it) expect_rec(a, s);
    tick();
    bus.src_ready[s] = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d records still pending, required 0", name, exp_q.size());
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every accepted head is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got addr %h src %0d, required no output",
                 bus.out_data.addr, bus.out_src);
      end else begin
        m_e = exp_q.pop_front();
        check("out_data", 64'(bus.out_data), {m_e.addr, m_e.data});
        check("out_src", 64'(bus.out_src), 64'(m_e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.src_ready = '0;
    bus.src_data  = '0;
    bus.counter   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_src", 64'(bus.out_src), 64'd0);
    check("rst_drop_count", 64'(bus.drop_count), 64'd0);
    check("rst_last_drop_time", 64'(bus.last_drop_time), 64'd0);
    rst = 1'b0;
    tick();
    tick();

    // Single IF record: visible two cycles after the edge is driven.
    bus.out_ready    = 1'b1;
    bus.counter      = 32'd5;
    bus.src_data[0]  = rec(32'h100);
    bus.src_ready[0] = 1'b1;
    expect_rec(32'h100, 1'b0);
    tick();
    bus.src_ready[0] = 1'b0;
    check("lat1_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("lat2_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat2_addr", 64'(bus.out_data.addr), 64'h100);
    check("lat2_src", 64'(bus.out_src), 64'd0);
    check("lat2_drop_count", 64'(bus.drop_count), 64'd0);
    wait_drain("single_drain");

    // Simultaneous edges after reset: source 0 wins first.
    do_reset();
    bus.src_data[0] = rec(32'h200);
    bus.src_data[1] = rec(32'h300);
    bus.src_ready   = 2'b11;
    expect_rec(32'h200, 1'b0);
    expect_rec(32'h300, 1'b1);
    tick();
    bus.src_ready = 2'b00;
    wait_drain("dual_drain");
    check("dual_drop_count", 64'(bus.drop_count), 64'd0);

    // Fill 8, hold a 9th, then drop a 10th.
    bus.out_ready = 1'b0;
    bus.counter   = 32'd40;
    for (int i = 0; i < 9; i++) pulse(1'b0, 32'h1000 + 32'(i), 1'b1);
    bus.counter = 32'd77;
    pulse(1'b0, 32'hDEAD, 1'b0);
    check("full_drop_count", 64'(bus.drop_count), 64'd1);
    check("full_last_drop_time", 64'(bus.last_drop_time), 64'd77);
    check("full_head_stable", 64'(bus.out_data.addr), 64'h1000);

    // Pop + push on a full FIFO while the same source captures: not a drop.
    bus.src_data[0]  = rec(32'h2000);
    bus.src_ready[0] = 1'b1;
    bus.out_ready    = 1'b1;
    expect_rec(32'h2000, 1'b0);
    tick();
    bus.src_ready[0] = 1'b0;
    check("grant_edge_drop_count", 64'(bus.drop_count), 64'd1);
    check("grant_edge_out_valid", 64'(bus.out_valid), 64'd1);
    wait_drain("full_drain");
    check("full_drain_empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-drain with 3 records queued.
    bus.out_ready = 1'b0;
    pulse(1'b1, 32'h3000, 1'b1);
    pulse(1'b1, 32'h3001, 1'b0);
    pulse(1'b1, 32'h3002, 1'b0);
    pulse(1'b1, 32'h3003, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_src", 64'(bus.out_src), 64'd0);
    check("midrst_drop_count", 64'(bus.drop_count), 64'd0);
    check("midrst_last_drop_time", 64'(bus.last_drop_time), 64'd0);
    bus.src_ready[0] = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_record", 64'(bus.out_valid), 64'd0);
    end
    bus.src_ready[0] = 1'b0;
    tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, the number of tracker sources (IF tracker is source 0).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the output FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port src_ready, input, NUM_SRC bits: per-source record-ready level (e.g. if_data_ready).
REQ-006 SHALL have port src_data, input, NUM_SRC x trace_output: per-source record.
REQ-007 SHALL have port counter, input, integer: global trace timestamp.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-009 SHALL have port out_data, output, trace_output: FIFO head record.
REQ-010 SHALL have port out_src, output, $clog2(NUM_SRC) bits: source index of the head record.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-012 SHALL have port drop_count, output, 32 bits: records lost, saturating.
REQ-013 SHALL have port last_drop_time, output, 32 bits: counter value at the most recent drop.

Function
REQ-014 SHALL detect a new record per source on the 0->1 edge of src_ready[i] (registered previous value); a level held high yields one capture.
REQ-015 SHALL latch src_data[i] into a one-entry per-source holding register on that edge, setting hold_valid[i].
REQ-016 SHALL, if hold_valid[i] is already set at a new edge, drop the new record, keep the held one, increment drop_count and load last_drop_time with counter.
REQ-017 SHALL grant one held source per cycle round-robin, starting after the last granted index; after reset, index 0 has priority.
REQ-018 SHALL grant only when the FIFO is not full or a pop happens in the same cycle.
REQ-019 SHALL write the granted record plus source index into the FIFO and clear hold_valid of that source in the same cycle.
REQ-020 SHALL accept a capture edge on the same source in the cycle its holding register is granted; this is not a drop.
REQ-021 SHALL present the FIFO head on out_valid/out_data/out_src with zero added latency; pop when out_valid and out_ready.
REQ-022 SHALL support simultaneous push and pop when full or empty; an empty FIFO with a push shows out_valid the next cycle.
REQ-023 SHALL keep capture-to-out_valid latency at 2 cycles when uncontended and FIFO empty.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, using an extra bit for full/empty.
REQ-025 SHALL saturate drop_count at 32'hFFFF_FFFF.
REQ-026 SHALL hold out_data stable while out_valid is high and out_ready is low.

Reset
REQ-027 SHALL, on rst high at any time, asynchronously clear the FIFO pointers, hold_valid, previous src_ready, and round-robin pointer (to 0), set out_valid=0, out_src=0, drop_count=0, last_drop_time=0; out_data is don't-care while out_valid=0.
REQ-028 SHALL discard all in-flight records on mid-operation reset and capture nothing while rst is high; a src_ready already high at deassertion SHALL NOT count as an edge.

Structure
REQ-029 SHALL take trace_output from ryuki_datatypes; the FIFO entry struct (record + source index) SHALL be added to that package.
REQ-030 SHALL implement the FIFO as sub-module trace_fifo (parameterised depth, push/pop/full/empty); arbitration and capture stay in trace_arbiter.

Verification
REQ-031 SHALL cover: a single IF pulse with addr=0x100, counter=5 -> out_valid 2 cycles later, out_data.addr=0x100, out_src=0, drop_count=0.
REQ-032 SHALL cover: both sources rising in the same cycle after reset -> source 0 is output first, then source 1, with no drops.
REQ-033 SHALL cover: source 0 with two edges while out_ready=0 and the FIFO is full -> the second is dropped, drop_count=1, last_drop_time equals counter at that edge.
REQ-034 SHALL cover: filling 8 entries with out_ready=0 -> 9th record held; raising out_ready -> all 9 drain in order, with one push and one pop in the same cycle.
REQ-035 SHALL cover: rst asserted mid-drain with 3 entries queued -> out_valid=0 immediately, and after release src_ready held high produces no record.
